// File: rtl/twisted_ring_counter.sv
// Parametrised Johnson / one-hot ring counter with load,
// direction, self-correction, index decode and wrap strobe.
module twisted_ring_counter #(
  parameter int WIDTH = 4,
  parameter int IDXW  = $clog2(2*WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] out,
  output logic [IDXW-1:0]  idx,
  output logic             wrap,
  output logic             illegal
);

  localparam int N2 = 2*WIDTH;

  logic             ring;
  logic             legal;
  logic [IDXW-1:0]  idx_j;
  logic [IDXW-1:0]  idx_r;
  logic [IDXW-1:0]  last;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] seed;
  int               pc;
  int               tr;
  int               pos;

  assign ring = (mode == 2'b01);

  // popcount, set-bit position and edge count of q
  always_comb begin
    pc  = 0;
    tr  = 0;
    pos = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (q[i]) begin
        pc  = pc + 1;
        pos = i;
      end
    end
    for (int i = 0; i < WIDTH-1; i++) begin
      if (q[i] != q[i+1]) tr = tr + 1;
    end
  end

  // legality and index decode; Johnson legal = one edge at most
  always_comb begin
    legal = ring ? (pc == 1) : (tr <= 1);
    idx_j = q[WIDTH-1] ? IDXW'(N2 - pc)
                       : IDXW'(pc);
    idx_r = IDXW'(pos);
    last  = ring ? IDXW'(WIDTH-1)
                 : IDXW'(N2-1);
    seed  = ring ? WIDTH'(1) : '0;
    if (!legal)    idx = '0;
    else if (ring) idx = idx_r;
    else           idx = idx_j;
  end

  // next-state for a legal enabled step
  always_comb begin
    shifted = q;
    unique case (1'b1)
      (!ring &&  dir):
        shifted = {q[WIDTH-2:0], ~q[WIDTH-1]};
      (!ring && !dir):
        shifted = {~q[0], q[WIDTH-1:1]};
      ( ring &&  dir):
        shifted = {q[WIDTH-2:0], q[WIDTH-1]};
      ( ring && !dir):
        shifted = {q[0], q[WIDTH-1:1]};
    endcase
  end

  // state, lagged copy and strobes
  always_ff @(posedge clk) begin
    if (!rst) begin
      q       <= '0;
      out     <= '0;
      wrap    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      out     <= q;
      wrap    <= 1'b0;
      illegal <= 1'b0;
      if (load) begin
        q <= load_val;
      end else if (en && !mode[1]) begin
        if (!legal) begin
          q       <= seed;
          illegal <= 1'b1;
        end else begin
          q    <= shifted;
          wrap <= dir ? (idx == last)
                      : (idx == '0);
        end
      end
    end
  end

endmodule

// File: doc/twisted_ring_counter.md
Name: twisted_ring_counter

Overview:
- Parametrised successor to the fixed 4-bit Johnson counter.
- Generalises width and adds a ring (one-hot) mode, up/down direction, count enable, parallel load, illegal-state self-correction, a decoded count index and a terminal/wrap strobe.
- Used as a sequencer and phase generator (multi-phase enables, LED chasers, timing slots) in the codebase's small-peripheral designs.

Parameters:
- WIDTH, 4, number of flip-flops in the ring; must be ≥ 2.
- IDXW, $clog2(2*WIDTH), width of the idx output (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- en  input  1  step enable; 1 = advance one state this cycle.
- dir  input  1  1 = up (shift toward MSB), 0 = down (shift toward LSB).
- mode  input  2  00 = Johnson, 01 = ring, 10/11 = hold.
- load  input  1  parallel load strobe.
- load_val  input  WIDTH  value written to q on load.
- q  output  WIDTH  counter state, registered.
- out  output  WIDTH  q delayed by one cycle, registered.
- idx  output  IDXW  decoded count index, combinational from q and mode.
- wrap  output  1  terminal strobe, registered.
- illegal  output  1  self-correction strobe, registered.

Behaviour:
- Reset (rst = 0 at posedge): q = 0, out = 0, wrap = 0, illegal = 0. Reset overrides every other input.
- Priority when rst = 1: load > (en and mode in {00, 01}) > hold.
- load = 1: q <= load_val, loaded unchecked. wrap = 0, illegal = 0.
- out <= q on every posedge with rst = 1, independent of en, load and mode. This gives a one-cycle lag.
- Johnson mode (00):
  - Legal states are the 2*WIDTH patterns of contiguous ones anchored at the LSB or the MSB.
  - Up: q <= {q[WIDTH-2:0], ~q[WIDTH-1]}.
  - Down: q <= {~q[0], q[WIDTH-1:1]}.
  - idx = popcount(q) if q[WIDTH-1] = 0, else 2*WIDTH − popcount(q).
- Ring mode (01):
  - Legal states are exactly one bit set.
  - Up: rotate left. Down: rotate right.
  - idx = position of the set bit, range 0..WIDTH-1.
- Hold modes (10, 11): q unchanged regardless of en. wrap = 0, illegal = 0.
- Illegal-state correction, checked only on an enabled step (en = 1, load = 0, mode 00/01):
  - If the current q is illegal for the mode, the step is replaced by q <= seed, and illegal = 1 for one cycle.
  - Seed is 0 in Johnson mode and 1 (bit 0) in ring mode.
  - No shift happens on a correction step, and wrap = 0.
  - All-zero is illegal in ring mode, so the first enabled ring step after reset corrects 0 to 1.
- idx = 0 whenever q is illegal for the current mode. In hold modes idx uses the Johnson decode.
- wrap: one-cycle pulse, registered with the step it describes.
  - Up: set when the step moves q from the last state (idx = N−1) to idx = 0.
  - Down: set when the step moves q from idx = 0 to idx = N−1.
  - N = 2*WIDTH in Johnson mode, WIDTH in ring mode.
  - Never set on load, correction or hold.
- Timing: dir or mode may change on any cycle. The step uses the values sampled at that edge. No extra latency; q updates on the same edge.
- Reset mid-sequence: q = 0 at the next edge; wrap and illegal are cleared in the same edge.

Test Plan:
- WIDTH = 4, Johnson up: rst low for 1 cycle, then en = 1, dir = 1 → q = 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000. idx follows 1..7, 0. wrap = 1 only on the 1000→0000 step. out lags q by one cycle.
- Johnson down from reset → q = 1000, 1100, 1110, 1111, 0111, 0011, 0001, 0000. wrap = 1 on the 0000→1000 step; idx = 7 there.
- Ring mode after reset, en = 1, dir = 1 → first edge: q 0000→0001 with illegal = 1 and wrap = 0. Then 0010, 0100, 1000, 0001, with wrap = 1 on the 1000→0001 step.
- Load and correction: load = 1, load_val = 0101 in Johnson mode → q = 0101, idx = 0. Next enabled step: q = 0000, illegal = 1. Assert load and en together with load_val = 0011 → q = 0011, no shift.
- Hold and direction change: at q = 0111 set mode = 10, en = 1 for 3 cycles → q stays 0111. Then mode = 00, dir = 0 → q = 0011, then 0001.
- Reset mid-count: at q = 1110 assert rst = 0 for one edge → q = 0000, out = 0000, wrap = 0, illegal = 0. Counting resumes from 0000 once rst = 1.
